// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared types and format helpers for the pipelined FP multiplier
package fp_pkg;

  typedef enum logic [1:0] {FP_ZERO, FP_NORM, FP_INF, FP_NAN} fp_class_t;

  function automatic int bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Canonical quiet NaN: positive, all-ones exponent, only the top fraction bit set.
  function automatic logic [63:0] qnan(input int exp_w, input int man_w);
    logic [63:0] ones;
    ones = (64'd1 << exp_w) - 64'd1;
    return (ones << man_w) | (64'd1 << (man_w - 1));
  endfunction

endpackage

// File: rtl/fp_classify.sv
// rtl/fp_classify.sv - splits one operand into class, sign, exponent and significand
module fp_classify
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [EXP_W+MAN_W:0] x,
  output fp_class_t            cls,
  output logic                 sign,
  output logic [EXP_W-1:0]     expo,
  output logic [MAN_W:0]       sig
);

  logic [MAN_W-1:0] frac;

  assign sign = x[EXP_W+MAN_W];
  assign expo = x[EXP_W+MAN_W-1:MAN_W];
  assign frac = x[MAN_W-1:0];

  // Denormals collapse to zero, so the hidden bit is 1 for every non-zero class.
  always_comb begin
    sig = {1'b1, frac};
    if (expo == '0) begin
      cls = FP_ZERO;
      sig = '0;
    end else if (&expo) begin
      cls = (frac == '0) ? FP_INF : FP_NAN;
    end else begin
      cls = FP_NORM;
    end
  end

endmodule

// File: rtl/fp_mult_pipe.sv
// rtl/fp_mult_pipe.sv - valid/ready pipelined floating-point multiplier with RNE rounding
module fp_mult_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] A,
  input  logic [EXP_W+MAN_W:0] B,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] result,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 overflow,
  output logic                 underflow,
  output logic                 invalid
);

  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int SW  = MAN_W + 1;
  localparam int PW  = 2 * SW;
  localparam int EW2 = EXP_W + 2;

  localparam logic [EW2-1:0] BIAS_E = EW2'(bias(EXP_W));
  localparam logic [EW2-1:0] EMAX   = EW2'((1 << EXP_W) - 1);
  localparam logic [EW2-1:0] ONE_E  = EW2'(1);
  localparam logic [63:0]    QNAN64 = qnan(EXP_W, MAN_W);
  localparam logic [W-1:0]   QNAN   = QNAN64[W-1:0];

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
  } s1_t;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic             sign;
    fp_class_t        cls;
    logic             invalid;
    logic [EW2-1:0]   expo;
    logic [PW-1:0]    prod;
  } s2_t;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic             sign;
    fp_class_t        cls;
    logic             invalid;
    logic [EW2-1:0]   expo;
    logic [PW-1:0]    norm;
  } s3_t;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [W-1:0]     result;
    logic             overflow;
    logic             underflow;
    logic             invalid;
  } out_t;

  s1_t  s1_q, s1_d;
  s2_t  s2_q, s2_d, s2_n;
  s3_t  s3_q, s3_d, s3_n;
  out_t o_q, o_d, o_n;
  logic en;

  fp_class_t        cls_a, cls_b;
  logic             sign_a, sign_b;
  logic [EXP_W-1:0] exp_a, exp_b;
  logic [MAN_W:0]   sig_a, sig_b;

  logic [SW-1:0]    kept;
  logic             guard, sticky, round_up;
  logic [SW:0]      rounded;
  logic [EW2-1:0]   e_fin;
  logic [MAN_W-1:0] frac_fin;

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (
    .x(s1_q.a), .cls(cls_a), .sign(sign_a), .expo(exp_a), .sig(sig_a)
  );

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (
    .x(s1_q.b), .cls(cls_b), .sign(sign_b), .expo(exp_b), .sig(sig_b)
  );

  assign en       = !o_q.valid || out_ready;
  assign in_ready = en;

  always_comb begin
    s2_n         = '0;
    s2_n.valid   = s1_q.valid;
    s2_n.tag     = s1_q.tag;
    s2_n.sign    = sign_a ^ sign_b;
    s2_n.invalid = (cls_a == FP_INF && cls_b == FP_ZERO) || (cls_a == FP_ZERO && cls_b == FP_INF);
    if (cls_a == FP_NAN || cls_b == FP_NAN || s2_n.invalid)  s2_n.cls = FP_NAN;
    else if (cls_a == FP_INF || cls_b == FP_INF)             s2_n.cls = FP_INF;
    else if (cls_a == FP_ZERO || cls_b == FP_ZERO)           s2_n.cls = FP_ZERO;
    else                                                     s2_n.cls = FP_NORM;
    s2_n.expo = {2'b00, exp_a} + {2'b00, exp_b} - BIAS_E;
    s2_n.prod = {{SW{1'b0}}, sig_a} * {{SW{1'b0}}, sig_b};
  end

  // Product of two [1,2) significands lies in [1,4): at most one left shift.
  always_comb begin
    s3_n         = '0;
    s3_n.valid   = s2_q.valid;
    s3_n.tag     = s2_q.tag;
    s3_n.sign    = s2_q.sign;
    s3_n.cls     = s2_q.cls;
    s3_n.invalid = s2_q.invalid;
    if (s2_q.prod[PW-1]) begin
      s3_n.norm = s2_q.prod;
      s3_n.expo = s2_q.expo + ONE_E;
    end else begin
      s3_n.norm = s2_q.prod << 1;
      s3_n.expo = s2_q.expo;
    end
  end

  always_comb begin
    kept     = s3_q.norm[PW-1:SW];
    guard    = s3_q.norm[MAN_W];
    sticky   = |s3_q.norm[MAN_W-1:0];
    round_up = guard && (sticky || kept[0]);
    rounded  = {1'b0, kept} + {{SW{1'b0}}, round_up};
    if (rounded[SW]) begin
      frac_fin = rounded[MAN_W:1];
      e_fin    = s3_q.expo + ONE_E;
    end else begin
      frac_fin = rounded[MAN_W-1:0];
      e_fin    = s3_q.expo;
    end

    o_n       = '0;
    o_n.valid = s3_q.valid;
    o_n.tag   = s3_q.tag;
    case (s3_q.cls)
      FP_NAN: begin
        o_n.result  = QNAN;
        o_n.invalid = s3_q.invalid;
      end
      FP_INF:  o_n.result = {s3_q.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      FP_ZERO: o_n.result = {s3_q.sign, {(W-1){1'b0}}};
      default: begin
        if ($signed(e_fin) >= $signed(EMAX)) begin
          o_n.result   = {s3_q.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          o_n.overflow = 1'b1;
        end else if ($signed(e_fin) < $signed(ONE_E)) begin
          o_n.result    = {s3_q.sign, {(W-1){1'b0}}};
          o_n.underflow = 1'b1;
        end else begin
          o_n.result = {s3_q.sign, e_fin[EXP_W-1:0], frac_fin};
        end
      end
    endcase
    if (!s3_q.valid) begin
      o_n.overflow  = 1'b0;
      o_n.underflow = 1'b0;
      o_n.invalid   = 1'b0;
    end
  end

  // One global enable: every stage shifts together, bubbles included.
  always_comb begin
    s1_d = s1_q;
    s2_d = s2_q;
    s3_d = s3_q;
    o_d  = o_q;
    if (en) begin
      s1_d.valid = in_valid;
      s1_d.tag   = in_tag;
      s1_d.a     = A;
      s1_d.b     = B;
      s2_d       = s2_n;
      s3_d       = s3_n;
      o_d        = o_n;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
      o_q  <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
      o_q  <= o_d;
    end
  end

  assign out_valid = o_q.valid;
  assign result    = o_q.result;
  assign out_tag   = o_q.tag;
  assign overflow  = o_q.overflow;
  assign underflow = o_q.underflow;
  assign invalid   = o_q.invalid;

endmodule

// File: tb/tb_fp_mult_pipe.sv
// tb/tb_fp_mult_pipe.sv - directed self-checking bench for fp_mult_pipe (binary32)
module tb_fp_mult_pipe;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int TAG_W = 4;
  localparam int W     = 32;

  logic             clk, rst_n;
  logic             in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]     A, B, result;
  logic [TAG_W-1:0] in_tag, out_tag;
  logic             overflow, underflow, invalid;

  int checks = 0;
  int errors = 0;

  fp_mult_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .out_tag(out_tag),
    .overflow(overflow), .underflow(underflow), .invalid(invalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
    in_valid = 1'b1;
    A        = a;
    B        = b;
    in_tag   = tag;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    in_valid = 1'b0; out_ready = 1'b1; A = '0; B = '0; in_tag = '0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b expected 0", out_valid); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got %h expected 00000000", result); end
    checks++; if (out_tag !== 4'h0) begin errors++; $display("FAIL reset_out_tag got %h expected 0", out_tag); end
    checks++; if ({overflow, underflow, invalid} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b expected 000", {overflow, underflow, invalid}); end
    out_ready = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b expected 1", in_ready); end
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    drive_op(32'h40000000, 32'h3F800000, 4'd1);
    tick();
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %b expected 0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b expected 1", out_valid); end
    checks++; if (result !== 32'h40000000) begin errors++; $display("FAIL basic_result got %h expected 40000000", result); end
    checks++; if (out_tag !== 4'd1) begin errors++; $display("FAIL basic_tag got %h expected 1", out_tag); end
    checks++; if ({overflow, underflow, invalid} !== 3'b000) begin errors++; $display("FAIL basic_flags got %b expected 000", {overflow, underflow, invalid}); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] va [2], vb [2], vr [2];
    va = '{32'h40200000, 32'h3F800001};
    vb = '{32'h40600000, 32'h3F800001};
    vr = '{32'h410C0000, 32'h3F800002};
    for (int i = 0; i < 2; i++) drive_op(va[i], vb[i], 4'(i + 2));
    repeat (2) tick();
    for (int i = 0; i < 2; i++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d] got %b expected 1", i, out_valid); end
      checks++; if (result !== vr[i]) begin errors++; $display("FAIL b2b_result[%0d] got %h expected %h", i, result, vr[i]); end
      checks++; if (out_tag !== 4'(i + 2)) begin errors++; $display("FAIL b2b_tag[%0d] got %h expected %h", i, out_tag, 4'(i + 2)); end
      checks++; if ({overflow, underflow, invalid} !== 3'b000) begin errors++; $display("FAIL b2b_flags[%0d] got %b expected 000", i, {overflow, underflow, invalid}); end
      tick();
    end
  endtask

  task automatic test_rounding();
    logic [31:0] va [3], vb [3], vr [3];
    va = '{32'h3F800001, 32'h3F800003, 32'hC0000000};
    vb = '{32'h40400000, 32'h3FC00000, 32'h3F800000};
    vr = '{32'h40400002, 32'h3FC00004, 32'hC0000000};
    for (int i = 0; i < 3; i++) drive_op(va[i], vb[i], 4'(i + 4));
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL round_valid[%0d] got %b expected 1", i, out_valid); end
      checks++; if (result !== vr[i]) begin errors++; $display("FAIL round_result[%0d] got %h expected %h", i, result, vr[i]); end
      checks++; if (out_tag !== 4'(i + 4)) begin errors++; $display("FAIL round_tag[%0d] got %h expected %h", i, out_tag, 4'(i + 4)); end
      tick();
    end
  endtask

  task automatic test_special();
    logic [31:0] va [3], vb [3], vr [3];
    logic [2:0]  vf [3];
    va = '{32'h7F800000, 32'hFF800000, 32'hFF800001};
    vb = '{32'h00000000, 32'hFF800000, 32'h3F800000};
    vr = '{32'h7FC00000, 32'h7F800000, 32'h7FC00000};
    vf = '{3'b001, 3'b000, 3'b000};
    for (int i = 0; i < 3; i++) drive_op(va[i], vb[i], 4'(i + 7));
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL special_valid[%0d] got %b expected 1", i, out_valid); end
      checks++; if (result !== vr[i]) begin errors++; $display("FAIL special_result[%0d] got %h expected %h", i, result, vr[i]); end
      checks++; if ({overflow, underflow, invalid} !== vf[i]) begin errors++; $display("FAIL special_flags[%0d] got %b expected %b", i, {overflow, underflow, invalid}, vf[i]); end
      tick();
    end
  endtask

  task automatic test_zero_sign();
    logic [31:0] va [3], vb [3], vr [3];
    va = '{32'h80000000, 32'h00000001, 32'h00000001};
    vb = '{32'h40000000, 32'h3F800000, 32'hBF800000};
    vr = '{32'h80000000, 32'h00000000, 32'h80000000};
    for (int i = 0; i < 3; i++) drive_op(va[i], vb[i], 4'(i + 1));
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++; if (result !== vr[i]) begin errors++; $display("FAIL zero_result[%0d] got %h expected %h", i, result, vr[i]); end
      checks++; if ({overflow, underflow, invalid} !== 3'b000) begin errors++; $display("FAIL zero_flags[%0d] got %b expected 000", i, {overflow, underflow, invalid}); end
      tick();
    end
  endtask

  task automatic test_range();
    logic [31:0] va [2], vb [2], vr [2];
    logic [2:0]  vf [2];
    va = '{32'h7F000000, 32'h00800000};
    vb = '{32'h40000000, 32'h3F000000};
    vr = '{32'h7F800000, 32'h00000000};
    vf = '{3'b100, 3'b010};
    for (int i = 0; i < 2; i++) drive_op(va[i], vb[i], 4'(i + 10));
    repeat (2) tick();
    for (int i = 0; i < 2; i++) begin
      checks++; if (result !== vr[i]) begin errors++; $display("FAIL range_result[%0d] got %h expected %h", i, result, vr[i]); end
      checks++; if ({overflow, underflow, invalid} !== vf[i]) begin errors++; $display("FAIL range_flags[%0d] got %b expected %b", i, {overflow, underflow, invalid}, vf[i]); end
      tick();
    end
    checks++; if ({overflow, underflow, invalid} !== 3'b000) begin errors++; $display("FAIL range_idle_flags got %b expected 000", {overflow, underflow, invalid}); end
  endtask

  task automatic test_stall();
    logic [31:0] vb [5];
    int next_op, got;
    vb = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000};
    next_op = 0;
    got = 0;
    for (int c = 0; c < 40 && got < 5; c++) begin
      out_ready = (c >= 6);
      if (next_op < 5) begin
        in_valid = 1'b1; A = 32'h3F800000; B = vb[next_op]; in_tag = 4'(next_op + 1);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (c == 3) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_ready_before_full got %b expected 1", in_ready); end
      end
      if (c == 4 || c == 5) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready[c%0d] got %b expected 0", c, in_ready); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_out_valid[c%0d] got %b expected 1", c, out_valid); end
        checks++; if (result !== 32'h3F800000 || out_tag !== 4'd1) begin errors++; $display("FAIL stall_hold[c%0d] got %h/%h expected 3f800000/1", c, result, out_tag); end
      end
      if (in_valid && in_ready) next_op++;
      if (out_valid && out_ready) begin
        checks++; if (out_tag !== 4'(got + 1)) begin errors++; $display("FAIL stall_order[%0d] got tag %h expected %h", got, out_tag, 4'(got + 1)); end
        checks++; if (result !== vb[got]) begin errors++; $display("FAIL stall_result[%0d] got %h expected %h", got, result, vb[got]); end
        got++;
      end
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checks++; if (got !== 5) begin errors++; $display("FAIL stall_count got %0d expected 5", got); end
    for (int c = 0; c < 4; c++) begin
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_duplicate[%0d] got out_valid %b tag %h expected 0", c, out_valid, out_tag); end
      tick();
    end
  endtask

  task automatic test_reset_flush();
    drive_op(32'h40000000, 32'h40000000, 4'd9);
    drive_op(32'h40400000, 32'h40000000, 4'd10);
    drive_op(32'h40800000, 32'h40000000, 4'd11);
    rst_n = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid_after_reset got %b expected 0", out_valid); end
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_ghost[%0d] got out_valid %b tag %h expected 0", c, out_valid, out_tag); end
      tick();
    end
    drive_op(32'h40400000, 32'h40000000, 4'd7);
    tick();
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_early_valid got %b expected 0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flush_new_valid got %b expected 1", out_valid); end
    checks++; if (out_tag !== 4'd7) begin errors++; $display("FAIL flush_new_tag got %h expected 7", out_tag); end
    checks++; if (result !== 32'h40C00000) begin errors++; $display("FAIL flush_new_result got %h expected 40c00000", result); end
    tick();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; A = '0; B = '0; in_tag = '0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_rounding();
    test_special();
    test_zero_sign();
    test_range();
    test_stall();
    test_reset_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
